// File: rtl/alu_wb_seq.sv
// -----------------------------------------------------------------------------
// alu_wb_seq
//   Multi-cycle ALU / write-back sequencer for the 8x16 register-file datapath.
//   One operation takes five cycles: read operand A through the shared 8:1 read
//   mux, read operand B, execute, write back, then a one-cycle done pulse that
//   coincides with IDLE (a new start is accepted in that same cycle).
//
// Ports
//   clk      in   1      clock, all state updates on posedge
//   reset    in   1      asynchronous, active-low clear of all state
//   start    in   1      request, sampled only in IDLE
//   op       in   3      operation code, latched on accepted start
//   rs_a     in   SELW   source register A, latched on accepted start
//   rs_b     in   SELW   source register B, latched on accepted start
//   rd       in   SELW   destination register, latched on accepted start
//   rd_sel   out  SELW   read-mux select
//   rd_data  in   WIDTH  read-mux output (combinational from the bank)
//   wr_data  out  WIDTH  write data to the register bank
//   wr_load  out  NREG   one-hot bank load, non-zero only in WB
//   busy     out  1      high whenever the sequencer is not IDLE
//   done     out  1      one-cycle pulse after the write-back edge
//   carry    out  1      carry/borrow flag of the last executed op
//   zero     out  1      high when the last result was zero
// -----------------------------------------------------------------------------
module alu_wb_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SELW-1:0]  rs_a,
  input  logic [SELW-1:0]  rs_b,
  input  logic [SELW-1:0]  rd,
  output logic [SELW-1:0]  rd_sel,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] wr_data,
  output logic [NREG-1:0]  wr_load,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXE  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  state_t state, state_nxt;

  logic [2:0]       op_p0;
  logic [SELW-1:0]  rs_a_p0;
  logic [SELW-1:0]  rs_b_p0;
  logic [SELW-1:0]  rd_p0;
  logic [WIDTH-1:0] opa_p1;
  logic [WIDTH-1:0] opb_p2;
  logic [WIDTH-1:0] res_p3;
  logic             carry_p3;
  logic             zero_p3;
  logic             done_p4;
  logic [WIDTH:0]   alu_out;

  // Returns {carry, result}. All ops are unsigned and the result is
  // truncated to WIDTH bits; the extra MSB carries the flag.
  function automatic logic [WIDTH:0] alu_calc(input logic [2:0]       f,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (f)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_SHL:  r = {a, 1'b0};
      OP_SHR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_calc(op_p0, opa_p1, opb_p2);

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the mux select and load vector. Both outputs decode from
  // the state register alone, so an asynchronous reset forces them to zero
  // immediately and a write in progress is dropped before its edge.
  always_comb begin
    state_nxt = state;
    rd_sel    = '0;
    wr_load   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RDA;
        end
      end
      RDA: begin
        rd_sel    = rs_a_p0;
        state_nxt = RDB;
      end
      RDB: begin
        rd_sel    = rs_b_p0;
        state_nxt = EXE;
      end
      EXE: begin
        state_nxt = WB;
      end
      WB: begin
        wr_load[rd_p0] = 1'b1;
        state_nxt      = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // p0: command capture on an accepted start
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_p0   <= '0;
      rs_a_p0 <= '0;
      rs_b_p0 <= '0;
      rd_p0   <= '0;
    end else if (state == IDLE && start) begin
      op_p0   <= op;
      rs_a_p0 <= rs_a;
      rs_b_p0 <= rs_b;
      rd_p0   <= rd;
    end
  end

  // ---------------------------------------------------------------------------
  // p1/p2: operand capture from the read mux
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_p1 <= '0;
      opb_p2 <= '0;
    end else begin
      if (state == RDA) begin
        opa_p1 <= rd_data;
      end
      if (state == RDB) begin
        opb_p2 <= rd_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // p3: execute; result and flags register only here and hold otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_p3   <= '0;
      carry_p3 <= 1'b0;
      zero_p3  <= 1'b0;
    end else if (state == EXE) begin
      res_p3   <= alu_out[WIDTH-1:0];
      carry_p3 <= alu_out[WIDTH];
      zero_p3  <= (alu_out[WIDTH-1:0] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // p4: completion pulse in the cycle after write-back
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_p4 <= 1'b0;
    end else begin
      done_p4 <= (state == WB);
    end
  end

  // The result register only changes on the EXE->WB edge, so it already
  // presents the current result in WB and holds the last one elsewhere.
  assign wr_data = res_p3;
  assign busy    = (state != IDLE);
  assign done    = done_p4;
  assign carry   = carry_p3;
  assign zero    = zero_p3;

endmodule

// File: tb/tb_alu_wb_seq.sv
module tb_alu_wb_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  rs_a;
  logic [2:0]  rs_b;
  logic [2:0]  rd;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic [7:0]  wr_load;
  logic        busy;
  logic        done;
  logic        carry;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Register bank model: 8x16, combinational read, load on posedge.
  logic [15:0] bank [8];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;

  assign rd_data = bank[rd_sel];

  always @(posedge clk) begin
    if (pre_we) begin
      bank[pre_idx] <= pre_val;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_load[i]) bank[i] <= wr_data;
      end
    end
  end

  alu_wb_seq #(.WIDTH(16), .NREG(8), .SELW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_a    (rs_a),
    .rs_b    (rs_b),
    .rd      (rd),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .wr_data (wr_data),
    .wr_load (wr_load),
    .busy    (busy),
    .done    (done),
    .carry   (carry),
    .zero    (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observations captured by run_op, one per cycle of the operation.
  logic [2:0]  o_sel1, o_sel2, o_sel3;
  logic [7:0]  o_load4;
  logic [15:0] o_data4;
  logic        o_busy1, o_done5, o_busy5, o_carry, o_zero;

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Issues one op from IDLE and samples cycles 1..5 at the falling edge.
  // Command inputs are scrambled while busy; they must have no effect.
  task automatic run_op(input logic [2:0] o, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d);
    @(negedge clk);
    start = 1'b1; op = o; rs_a = a; rs_b = b; rd = d;
    @(negedge clk);
    start = 1'b0; op = ~o; rs_a = ~a; rs_b = ~b; rd = ~d;
    o_sel1 = rd_sel; o_busy1 = busy;
    @(negedge clk);
    o_sel2 = rd_sel;
    @(negedge clk);
    o_sel3 = rd_sel;
    @(negedge clk);
    o_load4 = wr_load; o_data4 = wr_data;
    @(negedge clk);
    o_done5 = done; o_busy5 = busy; o_carry = carry; o_zero = zero;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (rd_sel !== 3'd0)     begin n_fail++; $display("FAIL reset_rd_sel got %0h want 0", rd_sel); end
    n_checks++; if (wr_data !== 16'h0)   begin n_fail++; $display("FAIL reset_wr_data got %h want 0000", wr_data); end
    n_checks++; if (wr_load !== 8'h00)   begin n_fail++; $display("FAIL reset_wr_load got %h want 00", wr_load); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {carry, zero}); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL idle_wait_busy got %b want 0", busy); end
  endtask

  // Reset asserted mid-WB of an ADD to r5 must drop the write immediately.
  task automatic test_wb_reset;
    set_reg(3'd1, 16'hFFFF);
    set_reg(3'd2, 16'h0001);
    set_reg(3'd5, 16'h1234);
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_a = 3'd1; rs_b = 3'd2; rd = 3'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_load !== 8'h20)   begin n_fail++; $display("FAIL t1_pre_wr_load got %h want 20", wr_load); end
    n_checks++; if (carry !== 1'b1)      begin n_fail++; $display("FAIL t1_pre_carry got %b want 1", carry); end
    reset = 1'b0;
    #1;
    n_checks++; if (wr_load !== 8'h00)   begin n_fail++; $display("FAIL t1_wr_load got %h want 00", wr_load); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL t1_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL t1_done got %b want 0", done); end
    n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL t1_flags got %b want 00", {carry, zero}); end
    n_checks++; if (wr_data !== 16'h0)   begin n_fail++; $display("FAIL t1_wr_data got %h want 0000", wr_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bank[5] !== 16'h1234) begin n_fail++; $display("FAIL t1_r5 got %h want 1234", bank[5]); end
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL t1_after got %b want 00", {busy, done}); end
  endtask

  task automatic test_add;
    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'h0001);
    run_op(3'b000, 3'd1, 3'd2, 3'd3);
    n_checks++; if (o_sel1 !== 3'd1)     begin n_fail++; $display("FAIL t2_sel_a got %0d want 1", o_sel1); end
    n_checks++; if (o_busy1 !== 1'b1)    begin n_fail++; $display("FAIL t2_busy got %b want 1", o_busy1); end
    n_checks++; if (o_sel2 !== 3'd2)     begin n_fail++; $display("FAIL t2_sel_b got %0d want 2", o_sel2); end
    n_checks++; if (o_sel3 !== 3'd0)     begin n_fail++; $display("FAIL t2_sel_exe got %0d want 0", o_sel3); end
    n_checks++; if (o_load4 !== 8'h08)   begin n_fail++; $display("FAIL t2_wr_load got %h want 08", o_load4); end
    n_checks++; if (o_data4 !== 16'h8000) begin n_fail++; $display("FAIL t2_wr_data got %h want 8000", o_data4); end
    n_checks++; if ({o_done5, o_busy5} !== 2'b10) begin n_fail++; $display("FAIL t2_done_busy got %b want 10", {o_done5, o_busy5}); end
    n_checks++; if ({o_carry, o_zero} !== 2'b00) begin n_fail++; $display("FAIL t2_flags got %b want 00", {o_carry, o_zero}); end
    n_checks++; if (bank[3] !== 16'h8000) begin n_fail++; $display("FAIL t2_r3 got %h want 8000", bank[3]); end
    n_checks++; if (wr_load !== 8'h00)   begin n_fail++; $display("FAIL t2_load_idle got %h want 00", wr_load); end

    set_reg(3'd1, 16'hFFFF);
    set_reg(3'd0, 16'h5555);
    run_op(3'b000, 3'd1, 3'd2, 3'd0);
    n_checks++; if (o_load4 !== 8'h01)   begin n_fail++; $display("FAIL t3_wr_load got %h want 01", o_load4); end
    n_checks++; if (bank[0] !== 16'h0000) begin n_fail++; $display("FAIL t3_r0 got %h want 0000", bank[0]); end
    n_checks++; if ({o_carry, o_zero} !== 2'b11) begin n_fail++; $display("FAIL t3_flags got %b want 11", {o_carry, o_zero}); end
  endtask

  task automatic test_sub;
    set_reg(3'd4, 16'h0003);
    set_reg(3'd6, 16'h0005);
    run_op(3'b001, 3'd4, 3'd6, 3'd7);
    n_checks++; if (bank[7] !== 16'hFFFE) begin n_fail++; $display("FAIL t4_r7 got %h want fffe", bank[7]); end
    n_checks++; if ({o_carry, o_zero} !== 2'b10) begin n_fail++; $display("FAIL t4_flags got %b want 10", {o_carry, o_zero}); end
    run_op(3'b001, 3'd6, 3'd4, 3'd7);
    n_checks++; if (bank[7] !== 16'h0002) begin n_fail++; $display("FAIL t4b_r7 got %h want 0002", bank[7]); end
    n_checks++; if ({o_carry, o_zero} !== 2'b00) begin n_fail++; $display("FAIL t4b_flags got %b want 00", {o_carry, o_zero}); end
    n_checks++; if (wr_data !== 16'h0002) begin n_fail++; $display("FAIL t4b_wr_data_hold got %h want 0002", wr_data); end
  endtask

  task automatic test_shift;
    set_reg(3'd2, 16'h8001);
    run_op(3'b110, 3'd2, 3'd0, 3'd2);
    n_checks++; if (bank[2] !== 16'h0002) begin n_fail++; $display("FAIL t5_shl_r2 got %h want 0002", bank[2]); end
    n_checks++; if ({o_carry, o_zero} !== 2'b10) begin n_fail++; $display("FAIL t5_shl_flags got %b want 10", {o_carry, o_zero}); end
    set_reg(3'd1, 16'h0001);
    run_op(3'b111, 3'd1, 3'd3, 3'd1);
    n_checks++; if (bank[1] !== 16'h0000) begin n_fail++; $display("FAIL t5_shr_r1 got %h want 0000", bank[1]); end
    n_checks++; if ({o_carry, o_zero} !== 2'b11) begin n_fail++; $display("FAIL t5_shr_flags got %b want 11", {o_carry, o_zero}); end
  endtask

  task automatic test_logic;
    logic [2:0]  ops  [4];
    logic [15:0] exps [4];
    ops[0] = 3'b010; exps[0] = 16'h3030;
    ops[1] = 3'b011; exps[1] = 16'hFCFC;
    ops[2] = 3'b100; exps[2] = 16'hCCCC;
    ops[3] = 3'b101; exps[3] = 16'h0F0F;
    set_reg(3'd4, 16'hF0F0);
    set_reg(3'd6, 16'h3C3C);
    for (int k = 0; k < 4; k++) begin
      run_op(ops[k], 3'd4, 3'd6, 3'd5);
      n_checks++; if (bank[5] !== exps[k]) begin n_fail++; $display("FAIL logic_op%0d_r5 got %h want %h", ops[k], bank[5], exps[k]); end
      n_checks++; if ({o_carry, o_zero} !== 2'b00) begin n_fail++; $display("FAIL logic_op%0d_flags got %b want 00", ops[k], {o_carry, o_zero}); end
    end
  endtask

  // start held high: accepted at edges 0 and 5 only, r2 doubles twice.
  task automatic test_back_to_back;
    logic [2:0] e_sel;
    logic [7:0] e_load;
    logic       e_busy, e_done;
    int         ph;
    set_reg(3'd2, 16'h0001);
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_a = 3'd2; rs_b = 3'd2; rd = 3'd2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ph     = (c - 1) % 5;
      e_sel  = (c <= 10 && ph <= 1) ? 3'd2 : 3'd0;
      e_load = (c <= 10 && ph == 3) ? 8'h04 : 8'h00;
      e_busy = (c <= 10 && ph <= 3);
      e_done = (c <= 10 && ph == 4);
      n_checks++; if (rd_sel !== e_sel)   begin n_fail++; $display("FAIL b2b_c%0d_rd_sel got %0d want %0d", c, rd_sel, e_sel); end
      n_checks++; if (wr_load !== e_load) begin n_fail++; $display("FAIL b2b_c%0d_wr_load got %h want %h", c, wr_load, e_load); end
      n_checks++; if ({busy, done} !== {e_busy, e_done}) begin n_fail++; $display("FAIL b2b_c%0d_busy_done got %b want %b", c, {busy, done}, {e_busy, e_done}); end
      if (c == 5) begin
        n_checks++; if (bank[2] !== 16'h0002) begin n_fail++; $display("FAIL b2b_r2_first got %h want 0002", bank[2]); end
      end
      if (c == 10) begin
        n_checks++; if (bank[2] !== 16'h0004) begin n_fail++; $display("FAIL b2b_r2_second got %h want 0004", bank[2]); end
        start = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; rs_a = 3'd0; rs_b = 3'd0; rd = 3'd0;
    pre_we = 1'b0; pre_idx = 3'd0; pre_val = 16'h0;
    test_reset;
    test_wb_reset;
    test_add;
    test_sub;
    test_shift;
    test_logic;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
